dcache_nway: RTL and testbench
==============================

# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache controller; the next generation of the direct-mapped 512 B read-operand data cache. It sits between the read-operand/write-back request arbitration and the MMU line-fill/evict interface and accepts one physical-address request at a time. It adds configurable ways, sets and line size, round-robin replacement, an explicit evict handshake, and automatic two-line (split) access for line-crossing requests.

## Interface
Parameters:
- WAYS, 2: associativity, power of two, 1..8
- SETS, 32: sets, power of two
- LINE_BYTES, 16: line size, power of two, ≥ 8
- ADDR_W, 15: physical address width; tag = ADDR_W − log2(SETS) − log2(LINE_BYTES)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_size  in  2  0/1/2/3 = 1/2/4/8 bytes
- req_addr  in  ADDR_W  byte address, any alignment
- req_wdata  in  64  write data, little-endian, low bytes used
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  64  read data, zero-extended above size; 0 for writes
- evict_req  out  1  dirty victim writeback request
- evict_addr  out  ADDR_W  victim line address (offset bits 0)
- evict_data  out  LINE_BYTES*8  victim line
- evict_ack  in  1  MMU accepted eviction
- miss_req  out  1  line fill request
- miss_addr  out  ADDR_W  missing line address (offset bits 0)
- fill_data  in  LINE_BYTES*8  fill line, valid with fill_ack
- fill_ack  in  1  fill data valid this cycle

## Operation
- States: IDLE, LOOKUP, EVICT, FILL, RESP.
- IDLE: req_ready=1; on accept, register addr/size/we/wdata, part=0 → LOOKUP.
- Split: offset + bytes > LINE_BYTES. Part 0 covers offset..line end (low data bytes); part 1 covers line at addr+LINE_BYTES (modulo 2^ADDR_W), offset 0, remaining bytes.
- LOOKUP: compare tag across all ways of indexed set. Hit: read merges bytes into result register, write updates bytes and sets dirty; if split and part=0 → part=1, stay LOOKUP; else → RESP.
- Miss: victim = lowest-index invalid way, else set's round-robin pointer. Victim valid & dirty → EVICT, else → FILL.
- EVICT: evict_req=1, evict_addr/data stable until evict_ack; on ack → FILL.
- FILL: miss_req=1, miss_addr stable until fill_ack; on ack write fill_data to victim, valid=1, dirty=0, pointer advances (mod WAYS) when victim came from pointer → LOOKUP (replay, guaranteed hit).
- Ack in the first cycle a request is raised is legal. Acks outside EVICT/FILL are ignored.
- RESP: rsp_valid=1 → IDLE.
- Reset: all outputs 0 (req_ready 0 in reset cycle, 1 first cycle after), state IDLE, all valid/dirty bits and pointers cleared; abandons any in-flight evict/fill, no response produced. Data/tag arrays not reset.

## Timing
- Accept cycle 0: single-line hit rsp_valid cycle 2; split double hit cycle 3; req_ready returns cycle 2 (with rsp_valid same cycle for next accept), giving max throughput 1 request / 2 cycles.
- Clean miss: miss_req from cycle 2; fill_ack in cycle k → rsp_valid at k+2 (non-split).
- Dirty miss: evict_req from cycle 2, miss_req the cycle after evict_ack.
- Split with misses: each part handles its own evict/fill sequence in order.

## Structure
- Package dcache_nway_pkg: state enum, size encoding, size-to-bytes function, derived widths (OFF_W, IDX_W, TAG_W) as functions of parameters.
- Sub-module dcache_set_array: per-way tag/valid/dirty/data storage with byte-masked write, combinational read, and all-valid clear on rst; instantiated once with WAYS-wide read output.

## Test plan
Default parameters; fill_data byte i = (line_addr>>4 + i) & 0xFF unless stated.
- Cold read 4B @0x0040 → miss_req, miss_addr=0x0040 cycle 2; fill_ack cycle 2 → rsp_valid cycle 4, rsp_rdata=0x07060504.
- Write 8B 0x1122334455667788 @0x0048 after fill → rsp cycle 2, no MMU traffic; read 8B @0x0048 → 0x1122334455667788.
- Conflict: dirty 0x0040, read 0x0240, read 0x0440 → evict_req evict_addr=0x0040 with written bytes, then miss_addr=0x0440; re-read 0x0240 hits.
- Split read 8B @0x004C with both lines resident → rsp_valid cycle 3, bytes 0..3 from 0x0040 offset C..F, bytes 4..7 from 0x0050 offset 0..3.
- Wrap: read 4B @0x7FFE cold → miss_addr 0x7FF0 then 0x0000.
- rst asserted while miss_req=1 → next cycle miss_req=0, rsp_valid=0, req_ready=1; read of previously resident 0x0040 misses.

Source files
------------

// File: rtl/dcache_nway_pkg.sv
// Shared types and width helpers for the N-way write-back data cache.
package dcache_nway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_1B = 2'd0,
        SZ_2B = 2'd1,
        SZ_4B = 2'd2,
        SZ_8B = 2'd3
    } size_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - idx_w(sets) - off_w(line_bytes);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_set_array.sv
// Per-way tag/valid/dirty/data storage: combinational read of one set, single write port
// that either fills a whole line (valid, clean) or byte-merges a store (dirty).
module dcache_set_array
    import dcache_nway_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 16,
    parameter int TAG_W      = 6,
    localparam int IDX_W     = idx_w(SETS),
    localparam int WAY_W     = way_w(WAYS),
    localparam int LINE_W    = LINE_BYTES * 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [WAYS-1:0][TAG_W-1:0]   rd_tag_o,
    output logic [WAYS-1:0]              rd_valid_o,
    output logic [WAYS-1:0]              rd_dirty_o,
    output logic [WAYS-1:0][LINE_W-1:0]  rd_data_o,
    input  logic                         wr_en_i,
    input  logic                         wr_fill_i,
    input  logic [WAY_W-1:0]             wr_way_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [TAG_W-1:0]             wr_tag_i,
    input  logic [LINE_BYTES-1:0]        wr_be_i,
    input  logic [LINE_W-1:0]            wr_data_i
);

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0]  tag_mem  [SETS];
        logic [LINE_W-1:0] data_mem [SETS];
        logic [SETS-1:0]   valid_q;
        logic [SETS-1:0]   dirty_q;
        logic              way_wr;

        assign way_wr = wr_en_i && (wr_way_i == WAY_W'(gi));

        // Tag and data contents are never reset; only the valid/dirty state is.
        always_ff @(posedge clk) begin
            if (way_wr) begin
                if (wr_fill_i) begin
                    tag_mem[wr_idx_i] <= wr_tag_i;
                end
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (wr_be_i[b]) begin
                        data_mem[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                dirty_q <= '0;
            end else if (way_wr) begin
                if (wr_fill_i) begin
                    valid_q[wr_idx_i] <= 1'b1;
                    dirty_q[wr_idx_i] <= 1'b0;
                end else begin
                    dirty_q[wr_idx_i] <= 1'b1;
                end
            end
        end

        assign rd_tag_o[gi]   = tag_mem[rd_idx_i];
        assign rd_data_o[gi]  = data_mem[rd_idx_i];
        assign rd_valid_o[gi] = valid_q[rd_idx_i];
        assign rd_dirty_o[gi] = dirty_q[rd_idx_i];
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache controller with round-robin
// replacement, evict/fill handshakes and automatic two-part access for line-crossing requests.
module dcache_nway
    import dcache_nway_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [63:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [63:0]             rsp_rdata,
    output logic                    evict_req,
    output logic [ADDR_W-1:0]       evict_addr,
    output logic [LINE_BYTES*8-1:0] evict_data,
    input  logic                    evict_ack,
    output logic                    miss_req,
    output logic [ADDR_W-1:0]       miss_addr,
    input  logic [LINE_BYTES*8-1:0] fill_data,
    input  logic                    fill_ack
);

    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int WAY_W  = way_w(WAYS);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int LN_W   = ADDR_W - OFF_W;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    size_e               size_q;
    logic                we_q;
    logic [63:0]         wdata_q;
    logic                part_q;
    logic [63:0]         rdata_q;
    logic [WAY_W-1:0]    victim_q;
    logic                victim_ptr_q;
    logic [WAY_W-1:0]    rr_q [SETS];
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [63:0]         rsp_rdata_q;
    logic                evict_req_q;
    logic [ADDR_W-1:0]   evict_addr_q;
    logic [LINE_W-1:0]   evict_data_q;
    logic                miss_req_q;
    logic [ADDR_W-1:0]   miss_addr_q;

    logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
    logic [WAYS-1:0]             rd_valid;
    logic [WAYS-1:0]             rd_dirty;
    logic [WAYS-1:0][LINE_W-1:0] rd_data;

    // Part 1 of a split access is the following line (wrapping at the top of memory).
    logic [LN_W-1:0]   cur_ln;
    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [ADDR_W-1:0] cur_line;

    assign cur_ln   = part_q ? addr_q[ADDR_W-1:OFF_W] + LN_W'(1) : addr_q[ADDR_W-1:OFF_W];
    assign cur_idx  = cur_ln[IDX_W-1:0];
    assign cur_tag  = cur_ln[LN_W-1 -: TAG_W];
    assign cur_line = {cur_ln, {OFF_W{1'b0}}};

    int   off_i;
    int   bytes_i;
    int   first_i;
    logic split;

    always_comb begin
        off_i   = int'(addr_q[OFF_W-1:0]);
        bytes_i = int'(size_bytes(size_q));
        split   = (off_i + bytes_i) > LINE_BYTES;
        first_i = split ? (LINE_BYTES - off_i) : bytes_i;
    end

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] victim;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = rr_q[cur_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid[w] && (rd_tag[w] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
    end

    // Line byte k pairs with request byte j; part 0 starts at the offset, part 1 resumes at first_i.
    logic [LINE_BYTES-1:0] be;
    logic [LINE_W-1:0]     line_wdata;
    logic [63:0]           merged;

    always_comb begin
        be         = '0;
        line_wdata = '0;
        merged     = rdata_q;
        for (int k = 0; k < LINE_BYTES; k++) begin
            for (int j = 0; j < 8; j++) begin
                if ((j < bytes_i) && (j == (part_q ? k + first_i : k - off_i))) begin
                    be[k]                = 1'b1;
                    line_wdata[k*8 +: 8] = wdata_q[j*8 +: 8];
                    if (!we_q) begin
                        merged[j*8 +: 8] = rd_data[hit_way][k*8 +: 8];
                    end
                end
            end
        end
    end

    logic fill_wr;
    logic store_wr;

    assign fill_wr  = (state_q == ST_FILL) && fill_ack;
    assign store_wr = (state_q == ST_LOOKUP) && hit && we_q;

    dcache_set_array #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_BYTES (LINE_BYTES),
        .TAG_W      (TAG_W)
    ) u_set_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (cur_idx),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_wr || store_wr),
        .wr_fill_i  (fill_wr),
        .wr_way_i   (fill_wr ? victim_q : hit_way),
        .wr_idx_i   (cur_idx),
        .wr_tag_i   (cur_tag),
        .wr_be_i    (fill_wr ? {LINE_BYTES{1'b1}} : be),
        .wr_data_i  (fill_wr ? fill_data : line_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            part_q       <= 1'b0;
            rdata_q      <= '0;
            victim_q     <= '0;
            victim_ptr_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            evict_req_q  <= 1'b0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            miss_req_q   <= 1'b0;
            miss_addr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        size_q      <= size_e'(req_size);
                        we_q        <= req_we;
                        wdata_q     <= req_wdata;
                        part_q      <= 1'b0;
                        rdata_q     <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        rdata_q <= merged;
                        if (split && !part_q) begin
                            part_q <= 1'b1;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= merged;
                            req_ready_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end else begin
                        victim_q     <= victim;
                        victim_ptr_q <= !inv_found;
                        if (rd_valid[victim] && rd_dirty[victim]) begin
                            evict_req_q  <= 1'b1;
                            evict_addr_q <= {rd_tag[victim], cur_idx, {OFF_W{1'b0}}};
                            evict_data_q <= rd_data[victim];
                            state_q      <= ST_EVICT;
                        end else begin
                            miss_req_q  <= 1'b1;
                            miss_addr_q <= cur_line;
                            state_q     <= ST_FILL;
                        end
                    end
                end
                ST_EVICT: begin
                    if (evict_ack) begin
                        evict_req_q <= 1'b0;
                        miss_req_q  <= 1'b1;
                        miss_addr_q <= cur_line;
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_ack) begin
                        miss_req_q <= 1'b0;
                        if (victim_ptr_q) begin
                            rr_q[cur_idx] <= (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                                  : rr_q[cur_idx] + WAY_W'(1);
                        end
                        state_q <= ST_LOOKUP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign evict_req  = evict_req_q;
    assign evict_addr = evict_addr_q;
    assign evict_data = evict_data_q;
    assign miss_req   = miss_req_q;
    assign miss_addr  = miss_addr_q;

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: cold miss, store hit, back-to-back, split, conflict eviction,
// address wrap and reset during an outstanding fill.
module tb_dcache_nway;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [1:0]   req_size = 2'd0;
    logic [14:0]  req_addr = '0;
    logic [63:0]  req_wdata = '0;
    logic         rsp_valid;
    logic [63:0]  rsp_rdata;
    logic         evict_req;
    logic [14:0]  evict_addr;
    logic [127:0] evict_data;
    logic         evict_ack = 1'b0;
    logic         miss_req;
    logic [14:0]  miss_addr;
    logic [127:0] fill_data = '0;
    logic         fill_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_nway #(
        .WAYS       (2),
        .SETS       (32),
        .LINE_BYTES (16),
        .ADDR_W     (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .evict_req  (evict_req),
        .evict_addr (evict_addr),
        .evict_data (evict_data),
        .evict_ack  (evict_ack),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .fill_data  (fill_data),
        .fill_ack   (fill_ack)
    );

    function automatic logic [127:0] fill_line(input logic [14:0] la);
        logic [127:0] l;
        logic [14:0]  b;
        b = la >> 4;
        for (int i = 0; i < 16; i++) begin
            l[i*8 +: 8] = 8'(b + 15'(i));
        end
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1 (one cycle after the accept edge).
    task automatic issue(input logic we, input logic [1:0] size, input logic [14:0] addr,
                         input logic [63:0] wdata);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_%h: req_ready=%b required 1", addr, req_ready);
        end
        $display("txn %s size=%0d addr=0x%h wdata=0x%h", we ? "WR" : "RD", size, addr, wdata);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b required 0", req_ready); end
        checks++; if (miss_req !== 1'b0) begin errors++; $display("FAIL rst_miss_req: got %b required 0", miss_req); end
        checks++; if (evict_req !== 1'b0) begin errors++; $display("FAIL rst_evict_req: got %b required 0", evict_req); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high: got %b required 1", req_ready); end
    endtask

    task automatic test_cold_read();
        issue(1'b0, 2'd2, 15'h0040, 64'h0);
        checks++; if (miss_req !== 1'b0) begin errors++; $display("FAIL cold_c1_miss: got %b required 0", miss_req); end
        step();
        checks++; if (miss_req !== 1'b1) begin errors++; $display("FAIL cold_c2_miss: got %b required 1", miss_req); end
        checks++; if (miss_addr !== 15'h0040) begin errors++; $display("FAIL cold_miss_addr: got %h required 0040", miss_addr); end
        fill_data = fill_line(15'h0040);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cold_c3_rsp: got %b required 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cold_c4_rsp: got %b required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h07060504) begin errors++; $display("FAIL cold_rdata: got %h required 07060504", rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cold_pulse: got %b required 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'd3, 15'h0048, 64'h1122334455667788);
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp: got %b required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL wr_rdata: got %h required 0", rsp_rdata); end
        checks++; if ((miss_req | evict_req) !== 1'b0) begin errors++; $display("FAIL wr_mmu: got miss=%b evict=%b required 0", miss_req, evict_req); end
        issue(1'b0, 2'd3, 15'h0048, 64'h0);
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp: got %b required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL b2b_rdata: got %h required 1122334455667788", rsp_rdata); end
        step();
    endtask

    task automatic test_split();
        issue(1'b0, 2'd2, 15'h0050, 64'h0);
        step();
        checks++; if (miss_addr !== 15'h0050) begin errors++; $display("FAIL split_pre_addr: got %h required 0050", miss_addr); end
        fill_data = fill_line(15'h0050);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        step();
        checks++; if (rsp_rdata !== 64'h08070605) begin errors++; $display("FAIL split_pre_rdata: got %h required 08070605", rsp_rdata); end
        step();
        issue(1'b0, 2'd3, 15'h004C, 64'h0);
        step();
        checks++; if (rsp_valid !== 1'b0 || miss_req !== 1'b0) begin errors++; $display("FAIL split_c2: got rsp=%b miss=%b required 0 0", rsp_valid, miss_req); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL split_c3_rsp: got %b required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h0807060511223344) begin errors++; $display("FAIL split_rdata: got %h required 0807060511223344", rsp_rdata); end
        step();
    endtask

    task automatic test_conflict();
        logic [127:0] exp_line;
        exp_line            = fill_line(15'h0040);
        exp_line[64 +: 64]  = 64'h1122334455667788;
        issue(1'b0, 2'd2, 15'h0240, 64'h0);
        step();
        checks++; if (evict_req !== 1'b0 || miss_addr !== 15'h0240) begin errors++; $display("FAIL conf_first: got evict=%b addr=%h required 0 0240", evict_req, miss_addr); end
        fill_data = fill_line(15'h0240);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        step();
        checks++; if (rsp_rdata !== 64'h27262524) begin errors++; $display("FAIL conf_first_rdata: got %h required 27262524", rsp_rdata); end
        step();
        issue(1'b0, 2'd2, 15'h0440, 64'h0);
        step();
        checks++; if (evict_req !== 1'b1 || miss_req !== 1'b0) begin errors++; $display("FAIL conf_evict_req: got evict=%b miss=%b required 1 0", evict_req, miss_req); end
        checks++; if (evict_addr !== 15'h0040) begin errors++; $display("FAIL conf_evict_addr: got %h required 0040", evict_addr); end
        checks++; if (evict_data !== exp_line) begin errors++; $display("FAIL conf_evict_data: got %h required %h", evict_data, exp_line); end
        evict_ack = 1'b1;
        step();
        evict_ack = 1'b0;
        checks++; if (evict_req !== 1'b0 || miss_req !== 1'b1) begin errors++; $display("FAIL conf_after_ack: got evict=%b miss=%b required 0 1", evict_req, miss_req); end
        checks++; if (miss_addr !== 15'h0440) begin errors++; $display("FAIL conf_miss_addr: got %h required 0440", miss_addr); end
        fill_data = fill_line(15'h0440);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h47464544) begin errors++; $display("FAIL conf_rdata: got v=%b %h required 1 47464544", rsp_valid, rsp_rdata); end
        step();
        issue(1'b0, 2'd2, 15'h0240, 64'h0);
        step();
        checks++; if (rsp_valid !== 1'b1 || miss_req !== 1'b0) begin errors++; $display("FAIL conf_rehit: got rsp=%b miss=%b required 1 0", rsp_valid, miss_req); end
        checks++; if (rsp_rdata !== 64'h27262524) begin errors++; $display("FAIL conf_rehit_rdata: got %h required 27262524", rsp_rdata); end
        step();
    endtask

    task automatic test_wrap();
        int n;
        issue(1'b0, 2'd2, 15'h7FFE, 64'h0);
        step();
        checks++; if (miss_req !== 1'b1 || miss_addr !== 15'h7FF0) begin errors++; $display("FAIL wrap_first: got miss=%b addr=%h required 1 7ff0", miss_req, miss_addr); end
        fill_data = fill_line(15'h7FF0);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        n = 0;
        while (!miss_req && n < 10) begin
            step();
            n++;
        end
        checks++; if (miss_req !== 1'b1) begin errors++; $display("FAIL wrap_second_timeout: got miss=%b required 1", miss_req); end
        checks++; if (miss_addr !== 15'h0000) begin errors++; $display("FAIL wrap_second_addr: got %h required 0000", miss_addr); end
        fill_data = fill_line(15'h0000);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_rsp_timeout: got %b required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h01000E0D) begin errors++; $display("FAIL wrap_rdata: got %h required 01000e0d", rsp_rdata); end
        step();
    endtask

    task automatic test_reset_abort();
        issue(1'b0, 2'd2, 15'h0800, 64'h0);
        step();
        checks++; if (miss_req !== 1'b1) begin errors++; $display("FAIL abort_pre_miss: got %b required 1", miss_req); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (miss_req !== 1'b0) begin errors++; $display("FAIL abort_miss_req: got %b required 0", miss_req); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %b required 1", req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got %b required 0", rsp_valid); end
        issue(1'b0, 2'd2, 15'h0040, 64'h0);
        step();
        checks++; if (miss_req !== 1'b1 || miss_addr !== 15'h0040) begin errors++; $display("FAIL abort_remiss: got miss=%b addr=%h required 1 0040", miss_req, miss_addr); end
        fill_data = fill_line(15'h0040);
        fill_ack  = 1'b1;
        step();
        fill_ack = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h07060504) begin errors++; $display("FAIL abort_refill_rdata: got v=%b %h required 1 07060504", rsp_valid, rsp_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_back_to_back();
        test_split();
        test_conflict();
        test_wrap();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
